updown_mod_counter: RTL and testbench
=====================================

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width in bits (2..32).
REQ-002 SHALL have parameter RST_VAL, default 0, value loaded on reset (must be <= MOD_DEF).
REQ-003 SHALL have parameter MOD_DEF, default 11, terminal value used when mod_max input is 0.
REQ-004 SHALL have port clk  input  1  single rising-edge clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port en  input  1  count-up request.
REQ-007 SHALL have port ds  input  1  count-down request.
REQ-008 SHALL have port load  input  1  synchronous load strobe.
REQ-009 SHALL have port load_val  input  WIDTH  value for load.
REQ-010 SHALL have port mod_max  input  WIDTH  terminal value; 0 selects MOD_DEF.
REQ-011 SHALL have port ctr  output  WIDTH  registered count value.
REQ-012 SHALL have port ovf  output  1  registered one-cycle pulse on up-wrap.
REQ-013 SHALL have port unf  output  1  registered one-cycle pulse on down-wrap.
REQ-014 SHALL have port cmd_err  output  1  sticky flag: en and ds both high seen.

Function
REQ-015 SHALL compute term = (mod_max == 0) ? MOD_DEF : mod_max each cycle; count range is 0..term inclusive.
REQ-016 SHALL apply per rising edge, priority order: rst, load, range-fix, up, down, hold.
REQ-017 SHALL on load set ctr = min(load_val, term); ovf/unf low.
REQ-018 SHALL on range-fix (ctr > term, no load) set ctr = 0, no pulse.
REQ-019 SHALL count up when en=1, ds=0: ctr+1; at ctr == term, ctr = 0 and ovf = 1 in same edge.
REQ-020 SHALL count down when en=0, ds=1: ctr-1; at ctr == 0, ctr = term and unf = 1 in same edge.
REQ-021 SHALL hold ctr when en == ds; en=ds=1 additionally sets cmd_err (cleared only by rst).
REQ-022 SHALL keep ovf and unf low in every cycle not named in REQ-019/020; never both high.
REQ-023 SHALL have latency of exactly one clock from input sample to ctr/flag update; no combinational input-to-output path.
REQ-024 SHALL perform all arithmetic in WIDTH bits; term = 2^WIDTH-1 gives natural wrap.

Reset
REQ-025 SHALL on rst=1 at a clock edge set ctr = RST_VAL, ovf = 0, unf = 0, cmd_err = 0, overriding all other inputs.
REQ-026 SHALL abort any in-progress operation on reset mid-sequence; first post-reset step starts from RST_VAL.

Configuration
REQ-027 SHALL support macro UDCTR_SATURATE_EN; when defined, add input port sat_mode (1 bit).
REQ-028 SHALL with UDCTR_SATURATE_EN and sat_mode=1 hold ctr at term (up) or 0 (down) instead of wrapping, still pulsing ovf/unf on each blocked step.
REQ-029 SHALL without UDCTR_SATURATE_EN omit sat_mode and always wrap per REQ-019/020.

Structure
REQ-030 SHALL place in package udctr_pkg: enum dir_t {DIR_HOLD, DIR_UP, DIR_DOWN, DIR_ERR} and a function decoding (en, ds) to dir_t.
REQ-031 SHALL contain one sub-module udctr_next, combinational next-state/flag logic; top holds registers only.

Verification (WIDTH=8, RST_VAL=0, MOD_DEF=11)
REQ-032 SHALL verify rst, then mod_max=0, en=1 ds=0 for 13 clocks -> ctr 1..11, 0, 1; ovf high only on the edge ctr becomes 0.
REQ-033 SHALL verify from ctr=0, en=0 ds=1 one clock -> ctr=11, unf=1; next clock ctr=10, unf=0.
REQ-034 SHALL verify load=1 load_val=200 with mod_max=50 -> ctr=50; then mod_max=20 with en=1 -> ctr=0, no ovf.
REQ-035 SHALL verify en=ds=1 for one clock at ctr=5 -> ctr stays 5, cmd_err=1 and remains 1 until rst.
REQ-036 SHALL verify rst=1 together with load=1 and en=1 at ctr=7 -> ctr=0, all flags 0.
REQ-037 SHALL verify (UDCTR_SATURATE_EN, sat_mode=1) at ctr=11, en=1 for 2 clocks -> ctr=11, ovf=1 both cycles.

Source files
------------

// File: rtl/udctr_pkg.sv
// udctr_pkg -- shared types for the up/down modulo counter.
//   dir_t        : decoded count direction for one clock edge.
//   udctr_decode : maps the (en, ds) request pair onto dir_t.
// Configuration macro: UDCTR_SATURATE_EN (not referenced here).
package udctr_pkg;

   typedef enum logic [1:0] {
      DIR_HOLD = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DOWN = 2'd2,
      DIR_ERR  = 2'd3
   } dir_t;

   // en=ds=1 is a conflicting request: the counter holds and the
   // sticky command-error flag is raised.
   function automatic dir_t udctr_decode(input logic en, input logic ds);
      dir_t d;
      case ({en, ds})
         2'b10:   d = DIR_UP;
         2'b01:   d = DIR_DOWN;
         2'b11:   d = DIR_ERR;
         default: d = DIR_HOLD;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/udctr_next.sv
// udctr_next -- combinational next-state and flag logic for updown_mod_counter.
// Ports:
//   ctr      in  WIDTH  current registered count
//   en, ds   in  1      up / down requests
//   load     in  1      load strobe
//   load_val in  WIDTH  load value (clamped to term)
//   mod_max  in  WIDTH  terminal value, 0 selects MOD_DEF
//   sat_mode in  1      1 = saturate instead of wrap (tied 0 unless
//                       UDCTR_SATURATE_EN is defined at the top)
//   ctr_nxt  out WIDTH  next count
//   ovf_nxt  out 1      next up-wrap pulse
//   unf_nxt  out 1      next down-wrap pulse
//   err_set  out 1      conflicting request seen this cycle
module udctr_next
   import udctr_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int MOD_DEF = 11
) (
   input  logic [WIDTH-1:0] ctr,
   input  logic             en,
   input  logic             ds,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] mod_max,
   input  logic             sat_mode,
   output logic [WIDTH-1:0] ctr_nxt,
   output logic             ovf_nxt,
   output logic             unf_nxt,
   output logic             err_set
);

   logic [WIDTH-1:0] term;
   dir_t             dir;

   always_comb begin
      term    = (mod_max == '0) ? WIDTH'(MOD_DEF) : mod_max;
      dir     = udctr_decode(en, ds);
      ctr_nxt = ctr;
      ovf_nxt = 1'b0;
      unf_nxt = 1'b0;
      err_set = (dir == DIR_ERR);

      if (load) begin
         ctr_nxt = (load_val > term) ? term : load_val;
      end else if (ctr > term) begin
         // mod_max was lowered below the current count: restart at 0 silently
         ctr_nxt = '0;
      end else begin
         case (dir)
            DIR_UP: begin
               if (ctr == term) begin
                  ovf_nxt = 1'b1;
                  ctr_nxt = sat_mode ? term : '0;
               end else begin
                  ctr_nxt = ctr + 1'b1;
               end
            end
            DIR_DOWN: begin
               if (ctr == '0) begin
                  unf_nxt = 1'b1;
                  ctr_nxt = sat_mode ? '0 : term;
               end else begin
                  ctr_nxt = ctr - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/updown_mod_counter.sv
// updown_mod_counter -- registered up/down counter over 0..term, where
// term = mod_max, or MOD_DEF when mod_max is 0.
// Ports:
//   clk      in  1      rising-edge clock
//   rst      in  1      synchronous active-high reset (ctr=RST_VAL, flags 0)
//   en       in  1      count-up request
//   ds       in  1      count-down request
//   load     in  1      synchronous load strobe
//   load_val in  WIDTH  load value
//   mod_max  in  WIDTH  terminal value, 0 selects MOD_DEF
//   sat_mode in  1      only when UDCTR_SATURATE_EN is defined: saturate
//   ctr      out WIDTH  registered count
//   ovf      out 1      registered pulse on up-wrap (or blocked up step)
//   unf      out 1      registered pulse on down-wrap (or blocked down step)
//   cmd_err  out 1      sticky: en and ds seen high together, cleared by rst
// Configuration macro: UDCTR_SATURATE_EN adds the sat_mode input.
module updown_mod_counter
   import udctr_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int RST_VAL = 0,
   parameter int MOD_DEF = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             ds,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] mod_max,
`ifdef UDCTR_SATURATE_EN
   input  logic             sat_mode,
`endif
   output logic [WIDTH-1:0] ctr,
   output logic             ovf,
   output logic             unf,
   output logic             cmd_err
);

   logic [WIDTH-1:0] ctr_nxt;
   logic             ovf_nxt;
   logic             unf_nxt;
   logic             err_set;
   logic             sat;

`ifdef UDCTR_SATURATE_EN
   assign sat = sat_mode;
`else
   assign sat = 1'b0;
`endif

   udctr_next #(
      .WIDTH   (WIDTH),
      .MOD_DEF (MOD_DEF)
   ) u_next (
      .ctr      (ctr),
      .en       (en),
      .ds       (ds),
      .load     (load),
      .load_val (load_val),
      .mod_max  (mod_max),
      .sat_mode (sat),
      .ctr_nxt  (ctr_nxt),
      .ovf_nxt  (ovf_nxt),
      .unf_nxt  (unf_nxt),
      .err_set  (err_set)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         ctr     <= WIDTH'(RST_VAL);
         ovf     <= 1'b0;
         unf     <= 1'b0;
         cmd_err <= 1'b0;
      end else begin
         ctr     <= ctr_nxt;
         ovf     <= ovf_nxt;
         unf     <= unf_nxt;
         cmd_err <= cmd_err | err_set;
      end
   end

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter -- directed self-checking bench for
// updown_mod_counter (WIDTH=8, RST_VAL=0, MOD_DEF=11).
// Saturation checks compile only when UDCTR_SATURATE_EN is defined.
module tb_updown_mod_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       ds = 1'b0;
   logic       load = 1'b0;
   logic [7:0] load_val = '0;
   logic [7:0] mod_max = '0;
`ifdef UDCTR_SATURATE_EN
   logic       sat_mode = 1'b0;
`endif
   logic [7:0] ctr;
   logic       ovf;
   logic       unf;
   logic       cmd_err;

   int unsigned nchecks = 0;
   int unsigned nerrors = 0;

   always #5 clk = ~clk;

   updown_mod_counter #(
      .WIDTH   (8),
      .RST_VAL (0),
      .MOD_DEF (11)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .ds       (ds),
      .load     (load),
      .load_val (load_val),
      .mod_max  (mod_max),
`ifdef UDCTR_SATURATE_EN
      .sat_mode (sat_mode),
`endif
      .ctr      (ctr),
      .ovf      (ovf),
      .unf      (unf),
      .cmd_err  (cmd_err)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerrors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // one rising edge, then settle before the caller samples / drives
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [7:0] c, input logic o,
                            input logic u, input logic e);
      check({tag, ".ctr"}, 32'(ctr), 32'(c));
      check({tag, ".ovf"}, 32'(ovf), 32'(o));
      check({tag, ".unf"}, 32'(unf), 32'(u));
      check({tag, ".cmd_err"}, 32'(cmd_err), 32'(e));
   endtask

   initial begin
      #1;
      // reset
      rst = 1'b1;
      step();
      check_all("reset", 8'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;

      // count up 13 clocks with term = MOD_DEF = 11
      en = 1'b1;
      for (int i = 1; i <= 13; i++) begin
         step();
         check($sformatf("up%0d.ctr", i), 32'(ctr), (i <= 11) ? 32'(i) : 32'(i - 12));
         check($sformatf("up%0d.ovf", i), 32'(ovf), (i == 12) ? 32'd1 : 32'd0);
      end
      en = 1'b0;

      // down from 0
      rst = 1'b1;
      step();
      rst = 1'b0;
      ds = 1'b1;
      step();
      check_all("dn_wrap", 8'd11, 1'b0, 1'b1, 1'b0);
      step();
      check_all("dn_next", 8'd10, 1'b0, 1'b0, 1'b0);
      ds = 1'b0;

      // hold
      step();
      check_all("hold", 8'd10, 1'b0, 1'b0, 1'b0);

      // load clamped, then range-fix when mod_max drops below ctr
      load = 1'b1; load_val = 8'd200; mod_max = 8'd50;
      step();
      check_all("load_clamp", 8'd50, 1'b0, 1'b0, 1'b0);
      load = 1'b0; mod_max = 8'd20; en = 1'b1;
      step();
      check_all("range_fix", 8'd0, 1'b0, 1'b0, 1'b0);
      en = 1'b0;

      // conflicting request sets sticky cmd_err
      mod_max = 8'd0; load = 1'b1; load_val = 8'd5;
      step();
      check("load5.ctr", 32'(ctr), 32'd5);
      load = 1'b0; en = 1'b1; ds = 1'b1;
      step();
      check_all("conflict", 8'd5, 1'b0, 1'b0, 1'b1);
      en = 1'b0; ds = 1'b0;
      step();
      check_all("err_sticky", 8'd5, 1'b0, 1'b0, 1'b1);
      en = 1'b1;
      step();
      check_all("err_sticky_up", 8'd6, 1'b0, 1'b0, 1'b1);
      en = 1'b0;

      // reset overrides load and en
      load = 1'b1; load_val = 8'd7;
      step();
      check("load7.ctr", 32'(ctr), 32'd7);
      rst = 1'b1; load = 1'b1; load_val = 8'd3; en = 1'b1;
      step();
      check_all("rst_override", 8'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0; load = 1'b0; en = 1'b0;

      // full-width term: natural wrap both ways
      mod_max = 8'd255; load = 1'b1; load_val = 8'd255;
      step();
      load = 1'b0; en = 1'b1;
      step();
      check_all("wrap255_up", 8'd0, 1'b1, 1'b0, 1'b0);
      en = 1'b0; ds = 1'b1;
      step();
      check_all("wrap255_dn", 8'd255, 1'b0, 1'b1, 1'b0);
      ds = 1'b0;
      step();
      check_all("wrap255_hold", 8'd255, 1'b0, 1'b0, 1'b0);

`ifdef UDCTR_SATURATE_EN
      mod_max = 8'd0; sat_mode = 1'b1; load = 1'b1; load_val = 8'd11;
      step();
      load = 1'b0; en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         check_all($sformatf("sat_up%0d", i), 8'd11, 1'b1, 1'b0, 1'b0);
      end
      en = 1'b0; load = 1'b1; load_val = 8'd0;
      step();
      load = 1'b0; ds = 1'b1;
      step();
      check_all("sat_dn", 8'd0, 1'b0, 1'b1, 1'b0);
      ds = 1'b0; sat_mode = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
      $finish;
   end

endmodule
